// File: rtl/jclock_stepper_pkg.sv
// Shared types and constants for the CPU timing stage: FSM encodings,
// quarter-phase codes and the per-quarter enable/set phase lookups.
package jclk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SSTEP = 2'd2
  } state_e;

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] RUN   = S_RUN;
  localparam logic [1:0] SSTEP = S_SSTEP;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Bit n of each lookup is the phase level during quarter n.
  localparam logic [3:0] CLKE_LUT = 4'b0111;
  localparam logic [3:0] CLKS_LUT = 4'b0010;

  function automatic logic phase_bit(input logic [3:0] lut, input logic [1:0] q);
    return lut[q];
  endfunction

endpackage

// File: rtl/jclock_stepper_if.sv
// Control/timing bundle between the CPU control logic (master) and the
// timing stage (slave).
interface jclock_stepper_if #(
  parameter int STEPS = 6
);
  // run/halt/step_clr are levels sampled on every rising clk edge; step_req is
  // a 1-clk pulse honoured only while the stage is idle and never queued.
  // There is no back-pressure: every output is a registered level or pulse.
  logic             run;
  logic             step_req;
  logic             halt;
  logic             step_clr;
  logic             clke;
  logic             clks;
  logic [STEPS-1:0] steps;
  logic             cycle_done;
  logic             running;
  logic [1:0]       dbg_state;

  modport master (
    output run, step_req, halt, step_clr,
    input  clke, clks, steps, cycle_done, running, dbg_state
  );

  modport slave (
    input  run, step_req, halt, step_clr,
    output clke, clks, steps, cycle_done, running, dbg_state
  );

endinterface

// File: rtl/jclock_stepper_jstepper.sv
// One-hot instruction step ring: rotates left on advance, clear forces step 1.
// Reset and clear both land on bit0 so the vector is never zero or multi-hot.
module jstepper #(
  parameter int STEPS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             clr,
  output logic [STEPS-1:0] steps
);

  localparam logic [STEPS-1:0] STEP1 = {{(STEPS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps <= STEP1;
    end else if (clr) begin
      steps <= STEP1;
    end else if (adv) begin
      steps <= {steps[STEPS-2:0], steps[STEPS-1]};
    end
  end

endmodule

// File: rtl/jclock_stepper.sv
// CPU timing stage: run/single-step/halt FSM, quarter-phase divider and
// registered clke/clks decode driving the one-hot step ring.
module jclock_stepper #(
  parameter int STEPS = 6,
  parameter int DIV   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  jclock_stepper_if.slave bus
);

  import jclk_pkg::*;

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clke_q, clks_q, done_q, running_q;
  logic          cycle_end;
  logic          active_d;

  // Next-state logic; outputs are registered from the *next* state so every
  // phase level changes cleanly on the same edge as the quarter itself.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    cycle_end = 1'b0;
    case (state_q)
      IDLE: begin
        q_d   = Q0;
        cnt_d = '0;
        if (bus.run && !bus.halt) begin
          state_d = RUN;
        end else if (bus.step_req && !bus.halt) begin
          state_d = SSTEP;
        end
      end
      RUN, SSTEP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (q_q == Q3) begin
            cycle_end = 1'b1;
            q_d       = Q0;
            if (!(state_q == RUN && bus.run && !bus.halt)) begin
              state_d = IDLE;
            end
          end else begin
            q_d = q_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = Q0;
        cnt_d   = '0;
      end
    endcase
  end

  assign active_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_q       <= Q0;
      cnt_q     <= '0;
      clke_q    <= 1'b0;
      clks_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      clke_q    <= active_d && phase_bit(CLKE_LUT, q_d);
      clks_q    <= active_d && phase_bit(CLKS_LUT, q_d);
      done_q    <= active_d && (q_d == Q3) && (cnt_d == CNT_LAST);
      running_q <= active_d;
    end
  end

  jstepper #(
    .STEPS(STEPS)
  ) u_stepper (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (cycle_end),
    .clr   (cycle_end && bus.step_clr),
    .steps (bus.steps)
  );

  assign bus.clke       = clke_q;
  assign bus.clks       = clks_q;
  assign bus.cycle_done = done_q;
  assign bus.running    = running_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_jclock_stepper.sv
// Directed bench for jclock_stepper: DIV=1 instance for run/step/halt/clear/reset
// behaviour, DIV=3 instance for quarter stretching.
module tb_jclock_stepper;

  localparam int STEPS = 6;

  logic clk;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] e_pat = 4'b0111;
  logic [3:0] s_pat = 4'b0010;
  logic [31:0] exp_q[$];

  jclock_stepper_if #(.STEPS(STEPS)) bus1 ();
  jclock_stepper_if #(.STEPS(STEPS)) bus3 ();

  jclock_stepper #(.STEPS(STEPS), .DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  jclock_stepper #(.STEPS(STEPS), .DIV(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_steps;
    int clks_cnt;
    int qq;

    rst_n         = 1'b0;
    bus1.run      = 1'b0;
    bus1.step_req = 1'b0;
    bus1.halt     = 1'b0;
    bus1.step_clr = 1'b0;
    bus3.run      = 1'b0;
    bus3.step_req = 1'b0;
    bus3.halt     = 1'b0;
    bus3.step_clr = 1'b0;

    repeat (2) tick();
    chk("rst_clke",    32'(bus1.clke), 32'd0);
    chk("rst_clks",    32'(bus1.clks), 32'd0);
    chk("rst_done",    32'(bus1.cycle_done), 32'd0);
    chk("rst_running", 32'(bus1.running), 32'd0);
    chk("rst_steps",   32'(bus1.steps), 32'h01);
    chk("rst_state",   32'(bus1.dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_clke", 32'(bus1.clke), 32'd0);

    // Free run, six full cycles, step ring wraps at the end
    for (int c = 0; c < STEPS; c++) exp_q.push_back(32'h1 << c);
    bus1.run = 1'b1;
    for (int c = 0; c < STEPS; c++) begin
      exp_steps = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("run_clke",    32'(bus1.clke), 32'(e_pat[k]));
        chk("run_clks",    32'(bus1.clks), 32'(s_pat[k]));
        chk("run_done",    32'(bus1.cycle_done), (k == 3) ? 32'd1 : 32'd0);
        chk("run_steps",   32'(bus1.steps), exp_steps);
        chk("run_running", 32'(bus1.running), 32'd1);
      end
    end
    bus1.run = 1'b0;
    tick();
    chk("stop_steps_wrap", 32'(bus1.steps), 32'h01);
    chk("stop_running",    32'(bus1.running), 32'd0);
    chk("stop_clke",       32'(bus1.clke), 32'd0);
    chk("stop_state",      32'(bus1.dbg_state), 32'd0);

    // Single step twice; an extra request mid-cycle is dropped
    bus1.step_req = 1'b1;
    tick();
    bus1.step_req = 1'b0;
    chk("ss1_q0_clke",  32'(bus1.clke), 32'd1);
    chk("ss1_running",  32'(bus1.running), 32'd1);
    chk("ss1_state",    32'(bus1.dbg_state), 32'd2);
    bus1.step_req = 1'b1;
    tick();
    bus1.step_req = 1'b0;
    chk("ss1_q1_clks",  32'(bus1.clks), 32'd1);
    tick();
    tick();
    chk("ss1_q3_done",  32'(bus1.cycle_done), 32'd1);
    chk("ss1_q3_clke",  32'(bus1.clke), 32'd0);
    tick();
    chk("ss1_end_steps",   32'(bus1.steps), 32'h02);
    chk("ss1_end_running", 32'(bus1.running), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gap_running", 32'(bus1.running), 32'd0);
      chk("gap_clke",    32'(bus1.clke), 32'd0);
      chk("gap_steps",   32'(bus1.steps), 32'h02);
    end
    bus1.step_req = 1'b1;
    tick();
    bus1.step_req = 1'b0;
    chk("ss2_running", 32'(bus1.running), 32'd1);
    repeat (3) tick();
    chk("ss2_q3_done", 32'(bus1.cycle_done), 32'd1);
    tick();
    chk("ss2_end_steps",   32'(bus1.steps), 32'h04);
    chk("ss2_end_running", 32'(bus1.running), 32'd0);

    // Halt raised in q1 of step 3: cycle completes, then idle
    bus1.run = 1'b1;
    tick();
    chk("h_q0_steps", 32'(bus1.steps), 32'h04);
    chk("h_q0_clke",  32'(bus1.clke), 32'd1);
    tick();
    chk("h_q1_clks",  32'(bus1.clks), 32'd1);
    bus1.halt = 1'b1;
    tick();
    chk("h_q2_clke",    32'(bus1.clke), 32'd1);
    chk("h_q2_running", 32'(bus1.running), 32'd1);
    tick();
    chk("h_q3_done",    32'(bus1.cycle_done), 32'd1);
    tick();
    chk("h_idle_running", 32'(bus1.running), 32'd0);
    chk("h_idle_clke",    32'(bus1.clke), 32'd0);
    chk("h_idle_steps",   32'(bus1.steps), 32'h08);
    tick();
    chk("h_hold_running", 32'(bus1.running), 32'd0);
    bus1.halt = 1'b0;
    tick();
    chk("resume_clke",    32'(bus1.clke), 32'd1);
    chk("resume_clks",    32'(bus1.clks), 32'd0);
    chk("resume_running", 32'(bus1.running), 32'd1);
    chk("resume_steps",   32'(bus1.steps), 32'h08);
    chk("resume_state",   32'(bus1.dbg_state), 32'd1);

    // step_clr on the last clk of step 4
    repeat (3) tick();
    chk("clr_q3_done", 32'(bus1.cycle_done), 32'd1);
    bus1.step_clr = 1'b1;
    tick();
    bus1.step_clr = 1'b0;
    chk("clr_steps", 32'(bus1.steps), 32'h01);
    chk("clr_clke",  32'(bus1.clke), 32'd1);

    // Reset asserted during q1 of step 5
    repeat (16) tick();
    chk("pre_rst_steps", 32'(bus1.steps), 32'h10);
    chk("pre_rst_clks",  32'(bus1.clks), 32'd0);
    tick();
    chk("pre_rst_q1_clks", 32'(bus1.clks), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_clke",    32'(bus1.clke), 32'd0);
    chk("async_clks",    32'(bus1.clks), 32'd0);
    chk("async_running", 32'(bus1.running), 32'd0);
    chk("async_steps",   32'(bus1.steps), 32'h01);
    chk("async_done",    32'(bus1.cycle_done), 32'd0);
    tick();
    chk("held_rst_clke", 32'(bus1.clke), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_clke",  32'(bus1.clke), 32'd1);
    chk("post_rst_clks",  32'(bus1.clks), 32'd0);
    chk("post_rst_steps", 32'(bus1.steps), 32'h01);
    bus1.run = 1'b0;
    repeat (4) tick();
    chk("post_rst_end_steps",   32'(bus1.steps), 32'h02);
    chk("post_rst_end_running", 32'(bus1.running), 32'd0);

    // DIV=3: each quarter spans three clks
    clks_cnt = 0;
    bus3.run = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      qq = ((t - 1) / 3) % 4;
      chk("d3_clke",  32'(bus3.clke), 32'(e_pat[qq]));
      chk("d3_clks",  32'(bus3.clks), 32'(s_pat[qq]));
      chk("d3_done",  32'(bus3.cycle_done), (((t - 1) % 12) == 11) ? 32'd1 : 32'd0);
      chk("d3_steps", 32'(bus3.steps), 32'h1 << ((t - 1) / 12));
      if (t <= 12 && bus3.clks) clks_cnt++;
    end
    chk("d3_clks_len", 32'(clks_cnt), 32'd3);
    bus3.run = 1'b0;
    tick();
    chk("d3_end_running", 32'(bus3.running), 32'd0);
    chk("d3_end_steps",   32'(bus3.steps), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jclock_stepper.md
Name: jclock_stepper

Overview:
- CPU timing stage: generates the enable phase (clke) and set phase (clks) plus the one-hot instruction step that the control logic ANDs into register `we`/`ws` lines.
- Sits directly upstream of the register file and enablers; every register set/enable pulse is qualified by its outputs.
- Provides free-run, single-step and halt control.

Parameters:
- STEPS, 6, number of instruction steps; width of the one-hot step vector (>=2).
- DIV, 1, system clocks per quarter-phase (>=1); one CPU cycle = 4*DIV clk cycles.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = free-run CPU cycles.
- step_req  input  1  1-clk pulse; request exactly one CPU cycle while stopped.
- halt  input  1  level from control logic; stop at end of current CPU cycle.
- step_clr  input  1  level; when high on the cycle's final clk, the next step is step 1.
- clke  output  1  enable phase; high in quarters 0,1,2 of an active cycle.
- clks  output  1  set phase; high in quarter 1 only.
- steps  output  STEPS  one-hot current step; bit0 = step 1.
- cycle_done  output  1  1-clk pulse on the final clk of quarter 3.
- running  output  1  high while a CPU cycle is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, quarter q=0, divider cnt=0.
  - clke=0, clks=0, cycle_done=0, running=0.
  - steps = one-hot 1 (bit0 set).
  - Reset mid-cycle aborts the cycle immediately; no partial step advance.
- States:
  - IDLE: outputs low, q=0, cnt=0.
  - RUN: free-running CPU cycles.
  - SSTEP: one cycle, then back to IDLE.
- IDLE transitions (evaluated each edge):
  - run=1 and halt=0 -> RUN.
  - Else step_req=1 and halt=0 -> SSTEP.
  - run has priority over step_req.
  - step_req outside IDLE is ignored; it is not queued.
- Quarter sequencing:
  - cnt counts 0..DIV-1; q advances 0->1->2->3 when cnt==DIV-1.
  - All outputs are registered and glitch-free.
  - Quarter 0 is visible from the edge that enters RUN or SSTEP.
- Phase encoding (all registered):
  - q0: clke=1, clks=0.
  - q1: clke=1, clks=1.
  - q2: clke=1, clks=0.
  - q3: clke=0, clks=0.
- End of cycle (edge after the last clk of q3):
  - steps rotates left; bit STEPS-1 wraps to bit0.
  - If step_clr was high on that last clk, steps = bit0 instead of rotating.
  - RUN continues (q=0) if run=1 and halt=0; otherwise -> IDLE.
  - SSTEP always -> IDLE.
- halt or run deassertion mid-cycle never truncates the cycle. The cycle always completes all 4 quarters.
- cycle_done is high exactly during the last clk of q3, once per completed cycle.
- running=1 in RUN/SSTEP, 0 in IDLE.
- steps holds its value while IDLE.
- steps is always exactly one-hot; never zero or multi-hot.
- Latency: run rise to clke rise = 1 clk edge. With DIV=1 a cycle is 4 clks; back-to-back cycles have no gap.

Decomposition:
- Package jclk_pkg:
  - state enum: IDLE, RUN, SSTEP.
  - 2-bit quarter constants: Q0..Q3.
  - phase lookup constants for clke/clks per quarter.
- Sub-module jstepper (one-hot ring with advance and clear inputs, async active-low reset to bit0).
- Parent holds the FSM, divider and phase decode.

Test Plan:
- Reset, then run=1 with DIV=1, STEPS=6:
  - clke pattern 1,1,1,0 repeating; clks pattern 0,1,0,0.
  - steps 000001->000010->...->100000->000001 over 6 cycles.
  - cycle_done every 4th clk.
- run=0, step_req pulse twice, separated by 10 clks:
  - Exactly two 4-clk cycles; steps 000001->000010->000100.
  - running low between cycles; extra step_req during a cycle ignored.
- halt asserted in q1 of step 3 while running:
  - Cycle finishes through q3; steps becomes 001000; then IDLE with clke=0.
  - Deasserting halt with run=1 resumes at q0.
- step_clr high during q3 of step 4:
  - Next steps = 000001, not 010000.
- rst_n pulsed low during q1 of step 5:
  - Outputs drop to 0 asynchronously; steps = 000001.
  - After release with run=1, a clean q0 starts.
- DIV=3:
  - Each quarter lasts 3 clks; clks high for exactly 3 clks; cycle_done high only on clk 12 of each cycle.
